// File: rtl/gpr_pkg.sv
// Shared definitions for the RISC-16 register-file writeback path.
package gpr_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 8;
  localparam int unsigned DATA_W     = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Which producer owns the register-file write port this cycle
  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_MEM
  } wb_src_t;

endpackage

// File: rtl/gpr_wb_ctrl_if.sv
// Producer handshakes and register-file write port of the writeback controller.
interface gpr_wb_ctrl_if #(
  parameter int unsigned DATA_W = gpr_pkg::DATA_W
);
  import gpr_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  reg_addr_t         alu_dest;
  logic [DATA_W-1:0] alu_data;

  logic              mem_valid;
  logic              mem_ready;
  reg_addr_t         mem_dest;
  logic [DATA_W-1:0] mem_data;

  logic              write_en;
  reg_addr_t         write_dest;
  logic [DATA_W-1:0] write_data;

  // Producer / register-file side
  modport master (
    output alu_valid, alu_dest, alu_data,
    output mem_valid, mem_dest, mem_data,
    input  alu_ready, mem_ready,
    input  write_en, write_dest, write_data
  );

  // Writeback controller side
  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  mem_valid, mem_dest, mem_data,
    output alu_ready, mem_ready,
    output write_en, write_dest, write_data
  );

endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register outstanding-write counters with hazard check ports.
// GPR_WB_FWD_EN adds forward-hit outputs and masks busy on the final pending write.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      reserve_en,
  input  reg_addr_t reserve_dest,
  input  logic      commit_en,
  input  reg_addr_t commit_dest,
  input  reg_addr_t chk_addr_1,
  input  reg_addr_t chk_addr_2,
  output logic      chk_busy_1,
  output logic      chk_busy_2,
`ifdef GPR_WB_FWD_EN
  output logic      fwd_hit_1,
  output logic      fwd_hit_2,
`endif
  output logic      sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_all;
  logic [NUM_REGS-1:0]            err_vec;
  logic                           sb_err_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    logic             res_hit;
    logic             com_hit;
    logic             ovf;
    logic             unf;
    logic [CNT_W-1:0] cnt_q;

    // r0 never accumulates: both hits are suppressed for index 0
    assign res_hit = (g != 0) && reserve_en && (reserve_dest == REG_ADDR_W'(g));
    assign com_hit = (g != 0) && commit_en  && (commit_dest  == REG_ADDR_W'(g));
    assign ovf     = res_hit && !com_hit && (cnt_q == CNT_MAX);
    assign unf     = com_hit && !res_hit && (cnt_q == '0);

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (res_hit && !com_hit && !ovf) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (com_hit && !res_hit && !unf) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end

    assign cnt_all[g] = cnt_q;
    assign err_vec[g] = ovf || unf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_q <= 1'b0;
    end else if (|err_vec) begin
      sb_err_q <= 1'b1;
    end
  end

  assign sb_err = sb_err_q;

  logic busy_raw_1;
  logic busy_raw_2;

  assign busy_raw_1 = (chk_addr_1 != '0) && (cnt_all[chk_addr_1] != '0);
  assign busy_raw_2 = (chk_addr_2 != '0) && (cnt_all[chk_addr_2] != '0);

`ifdef GPR_WB_FWD_EN
  assign fwd_hit_1 = commit_en && (commit_dest == chk_addr_1) && (chk_addr_1 != '0);
  assign fwd_hit_2 = commit_en && (commit_dest == chk_addr_2) && (chk_addr_2 != '0);

  // The committing write is the last one pending: decode can take it from the bypass
  assign chk_busy_1 = busy_raw_1 && !(fwd_hit_1 && (cnt_all[chk_addr_1] == CNT_W'(1)));
  assign chk_busy_2 = busy_raw_2 && !(fwd_hit_2 && (cnt_all[chk_addr_2] == CNT_W'(1)));
`else
  assign chk_busy_1 = busy_raw_1;
  assign chk_busy_2 = busy_raw_2;
`endif

endmodule

// File: rtl/gpr_wb_ctrl.sv
// Writeback controller: arbitrates ALU/load results onto the register-file write port.
// Optional bypass outputs are compiled in with GPR_WB_FWD_EN.
module gpr_wb_ctrl
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W       = gpr_pkg::DATA_W,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 2
) (
  input  logic              clk,
  input  logic              rst,
  gpr_wb_ctrl_if.slave      bus,
  input  logic              reserve_en,
  input  reg_addr_t         reserve_dest,
  input  reg_addr_t         chk_addr_1,
  input  reg_addr_t         chk_addr_2,
  output logic              chk_busy_1,
  output logic              chk_busy_2,
`ifdef GPR_WB_FWD_EN
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2,
`endif
  output logic              sb_err
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;
  logic                force_alu;
  logic                alu_ready;
  logic                mem_ready;
  wb_src_t             src;
  reg_addr_t           win_dest;
  logic [DATA_W-1:0]   win_data;
  logic                write_en_q;
  reg_addr_t           write_dest_q;
  logic [DATA_W-1:0]   write_data_q;

  // Memory wins unless the ALU has been starved long enough
  assign force_alu = (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign mem_ready = !force_alu;
  assign alu_ready = !bus.mem_valid || force_alu;

  always_comb begin
    src      = WB_NONE;
    win_dest = '0;
    win_data = '0;
    if (bus.mem_valid && mem_ready) begin
      src      = WB_MEM;
      win_dest = bus.mem_dest;
      win_data = bus.mem_data;
    end else if (bus.alu_valid && alu_ready) begin
      src      = WB_ALU;
      win_dest = bus.alu_dest;
      win_data = bus.alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (src == WB_ALU) begin
      starve_cnt <= '0;
    end else if (bus.alu_valid && !alu_ready && !force_alu) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Writes to r0 complete the handshake but never reach the register file
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en_q   <= 1'b0;
      write_dest_q <= '0;
      write_data_q <= '0;
    end else begin
      write_en_q <= (src != WB_NONE) && (win_dest != '0);
      if ((src != WB_NONE) && (win_dest != '0)) begin
        write_dest_q <= win_dest;
        write_data_q <= win_data;
      end
    end
  end

  assign bus.alu_ready  = alu_ready;
  assign bus.mem_ready  = mem_ready;
  assign bus.write_en   = write_en_q;
  assign bus.write_dest = write_dest_q;
  assign bus.write_data = write_data_q;

`ifdef GPR_WB_FWD_EN
  assign fwd_data_1 = write_data_q;
  assign fwd_data_2 = write_data_q;
`endif

  gpr_scoreboard #(
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .reserve_en   (reserve_en),
    .reserve_dest (reserve_dest),
    .commit_en    (write_en_q),
    .commit_dest  (write_dest_q),
    .chk_addr_1   (chk_addr_1),
    .chk_addr_2   (chk_addr_2),
    .chk_busy_1   (chk_busy_1),
    .chk_busy_2   (chk_busy_2),
`ifdef GPR_WB_FWD_EN
    .fwd_hit_1    (fwd_hit_1),
    .fwd_hit_2    (fwd_hit_2),
`endif
    .sb_err       (sb_err)
  );

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Self-checking bench for gpr_wb_ctrl: directed scenarios then random traffic vs. a behavioural model.
module tb_gpr_wb_ctrl;
  import gpr_pkg::*;

  localparam int STARVE_LIMIT = 4;
  localparam int CNT_MAX      = 3;

  logic      clk;
  logic      rst;
  logic      reserve_en;
  reg_addr_t reserve_dest;
  reg_addr_t chk_addr_1;
  reg_addr_t chk_addr_2;
  logic      chk_busy_1;
  logic      chk_busy_2;
  logic      sb_err;
`ifdef GPR_WB_FWD_EN
  logic        fwd_hit_1;
  logic        fwd_hit_2;
  logic [15:0] fwd_data_1;
  logic [15:0] fwd_data_2;
`endif

  gpr_wb_ctrl_if bus ();

  gpr_wb_ctrl #(
    .DATA_W       (16),
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .reserve_en   (reserve_en),
    .reserve_dest (reserve_dest),
    .chk_addr_1   (chk_addr_1),
    .chk_addr_2   (chk_addr_2),
    .chk_busy_1   (chk_busy_1),
    .chk_busy_2   (chk_busy_2),
`ifdef GPR_WB_FWD_EN
    .fwd_hit_1    (fwd_hit_1),
    .fwd_hit_2    (fwd_hit_2),
    .fwd_data_1   (fwd_data_1),
    .fwd_data_2   (fwd_data_2),
`endif
    .sb_err       (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending-write counts, starvation age, last committed write
  int cnt_m [NUM_REGS];
  int starve_m;
  bit we_m;
  int dest_m;
  int data_m;
  bit err_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) cnt_m[i] = 0;
    starve_m = 0;
    we_m     = 1'b0;
    dest_m   = 0;
    data_m   = 0;
    err_m    = 1'b0;
  endtask

  function automatic bit exp_busy(input int a);
    bit b;
    if (a == 0) return 1'b0;
    b = (cnt_m[a] != 0);
`ifdef GPR_WB_FWD_EN
    if (we_m && dest_m == a && cnt_m[a] == 1) b = 1'b0;
`endif
    return b;
  endfunction

  // Advance the model by one clock edge using the inputs presented this cycle
  task automatic model_step();
    bit ardy, mrdy, axf, mxf, starved;
    int delta;
    if (rst) begin
      model_reset();
      return;
    end
    starved = (starve_m == STARVE_LIMIT);
    mrdy = !starved;
    ardy = !bus.mem_valid || starved;
    mxf  = bus.mem_valid && mrdy;
    axf  = bus.alu_valid && ardy;
    for (int i = 1; i < NUM_REGS; i++) begin
      delta = 0;
      if (reserve_en && int'(reserve_dest) == i) delta++;
      if (we_m && dest_m == i) delta--;
      if (delta > 0) begin
        if (cnt_m[i] == CNT_MAX) err_m = 1'b1;
        else cnt_m[i]++;
      end else if (delta < 0) begin
        if (cnt_m[i] == 0) err_m = 1'b1;
        else cnt_m[i]--;
      end
    end
    if (axf) starve_m = 0;
    else if (bus.alu_valid && !ardy && starve_m < STARVE_LIMIT) starve_m++;
    we_m = 1'b0;
    if (mxf && bus.mem_dest != 0) begin
      we_m = 1'b1; dest_m = int'(bus.mem_dest); data_m = int'(bus.mem_data);
    end else if (axf && bus.alu_dest != 0) begin
      we_m = 1'b1; dest_m = int'(bus.alu_dest); data_m = int'(bus.alu_data);
    end
  endtask

  task automatic check_all();
    bit starved;
    #1;
    starved = (starve_m == STARVE_LIMIT);
    check_eq("alu_ready", 32'(bus.alu_ready), 32'(!bus.mem_valid || starved));
    check_eq("mem_ready", 32'(bus.mem_ready), 32'(!starved));
    check_eq("write_en",  32'(bus.write_en),  32'(we_m));
    if (we_m) begin
      check_eq("write_dest", 32'(bus.write_dest), 32'(dest_m));
      check_eq("write_data", 32'(bus.write_data), 32'(data_m));
    end
    check_eq("chk_busy_1", 32'(chk_busy_1), 32'(exp_busy(int'(chk_addr_1))));
    check_eq("chk_busy_2", 32'(chk_busy_2), 32'(exp_busy(int'(chk_addr_2))));
    check_eq("sb_err", 32'(sb_err), 32'(err_m));
`ifdef GPR_WB_FWD_EN
    check_eq("fwd_hit_1", 32'(fwd_hit_1), 32'(we_m && dest_m == int'(chk_addr_1) && chk_addr_1 != 0));
    check_eq("fwd_hit_2", 32'(fwd_hit_2), 32'(we_m && dest_m == int'(chk_addr_2) && chk_addr_2 != 0));
    if (we_m) check_eq("fwd_data_1", 32'(fwd_data_1), 32'(data_m));
`endif
  endtask

  task automatic tick();
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rst           = 1'b0;
    reserve_en    = 1'b0;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic alu_req(input int d, input int v);
    bus.alu_valid = 1'b1;
    bus.alu_dest  = REG_ADDR_W'(d);
    bus.alu_data  = 16'(v);
  endtask

  task automatic mem_req(input int d, input int v);
    bus.mem_valid = 1'b1;
    bus.mem_dest  = REG_ADDR_W'(d);
    bus.mem_data  = 16'(v);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    bus.alu_dest = '0; bus.alu_data = '0;
    bus.mem_dest = '0; bus.mem_data = '0;
    reserve_dest = '0; chk_addr_1 = '0; chk_addr_2 = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    check_eq("rst_write_en",   32'(bus.write_en),   32'd0);
    check_eq("rst_write_dest", 32'(bus.write_dest), 32'd0);
    check_eq("rst_write_data", 32'(bus.write_data), 32'd0);
    check_eq("rst_sb_err",     32'(sb_err),         32'd0);
    check_eq("rst_alu_ready",  32'(bus.alu_ready),  32'd1);
    check_eq("rst_mem_ready",  32'(bus.mem_ready),  32'd1);

    // Single ALU write, one-cycle latency
    alu_req(2, 'h1234);
    #1 check_eq("alu1_ready", 32'(bus.alu_ready), 32'd1);
    tick(); idle();
    #1;
    check_eq("alu1_we",   32'(bus.write_en),   32'd1);
    check_eq("alu1_dest", 32'(bus.write_dest), 32'd2);
    check_eq("alu1_data", 32'(bus.write_data), 32'h1234);
    tick();
    check_eq("alu1_we_drop", 32'(bus.write_en), 32'd0);

    // Memory priority, ALU held until mem_valid drops
    do_reset();
    alu_req(3, 'h0A0A); mem_req(4, 'h0B0B);
    #1 check_eq("prio_alu_stall", 32'(bus.alu_ready), 32'd0);
    tick(); bus.mem_valid = 1'b0;
    #1 check_eq("prio_mem_first", 32'(bus.write_dest), 32'd4);
    tick(); idle();
    #1 check_eq("prio_alu_next", 32'(bus.write_dest), 32'd3);
    tick();

    // Starvation: ALU forced after STARVE_LIMIT lost cycles
    alu_req(3, 'h0C0C); mem_req(4, 'h0D0D);
    for (int k = 0; k < STARVE_LIMIT; k++) begin
      #1 check_eq("starve_stall", 32'(bus.alu_ready), 32'd0);
      tick();
    end
    #1;
    check_eq("starve_alu_force", 32'(bus.alu_ready), 32'd1);
    check_eq("starve_mem_block", 32'(bus.mem_ready), 32'd0);
    tick(); bus.alu_valid = 1'b0;
    #1;
    check_eq("starve_alu_data", 32'(bus.write_data), 32'h0C0C);
    check_eq("starve_mem_back", 32'(bus.mem_ready), 32'd1);
    tick(); idle(); tick();

    // Reserve / commit / busy, with optional bypass
    do_reset();
    reserve_en = 1'b1; reserve_dest = 3'd5; chk_addr_1 = 3'd5;
    tick(); reserve_en = 1'b0;
    #1 check_eq("sb_busy_r5", 32'(chk_busy_1), 32'd1);
    alu_req(5, 'hBEEF);
    tick(); idle();
    #1;
`ifdef GPR_WB_FWD_EN
    check_eq("fwd_hit_r5",  32'(fwd_hit_1),  32'd1);
    check_eq("fwd_data_r5", 32'(fwd_data_1), 32'hBEEF);
    check_eq("fwd_busy_r5", 32'(chk_busy_1), 32'd0);
`else
    check_eq("sb_busy_wcyc", 32'(chk_busy_1), 32'd1);
`endif
    tick();
    #1;
    check_eq("sb_busy_clear", 32'(chk_busy_1), 32'd0);
    check_eq("sb_err_clean",  32'(sb_err),     32'd0);

    // r0 is never written nor tracked
    alu_req(0, 'hFFFF);
    #1 check_eq("r0_ready", 32'(bus.alu_ready), 32'd1);
    tick(); idle();
    #1 check_eq("r0_no_we", 32'(bus.write_en), 32'd0);
    reserve_en = 1'b1; reserve_dest = 3'd0; chk_addr_2 = 3'd0;
    tick(); reserve_en = 1'b0;
    #1;
    check_eq("r0_busy", 32'(chk_busy_2), 32'd0);
    check_eq("r0_err",  32'(sb_err),     32'd0);

    // Counter overflow
    chk_addr_1 = 3'd1;
    for (int k = 0; k < 4; k++) begin
      reserve_en = 1'b1; reserve_dest = 3'd1;
      tick(); reserve_en = 1'b0;
      #1 check_eq("ovf_err", 32'(sb_err), 32'(k == 3));
    end
    for (int k = 0; k < 3; k++) begin
      alu_req(1, k);
      tick(); idle(); tick();
    end
    #1 check_eq("ovf_held_at_3", 32'(chk_busy_1), 32'd0);

    // Commit with nothing outstanding
    do_reset();
    alu_req(6, 'h6666);
    tick(); idle(); tick();
    #1 check_eq("unf_err", 32'(sb_err), 32'd1);

    // Same-cycle reserve and commit cancel
    do_reset();
    chk_addr_1 = 3'd1;
    reserve_en = 1'b1; reserve_dest = 3'd1;
    tick(); reserve_en = 1'b0;
    alu_req(1, 'h1111);
    tick(); idle();
    reserve_en = 1'b1; reserve_dest = 3'd1;
    tick(); reserve_en = 1'b0;
    #1;
    check_eq("same_busy", 32'(chk_busy_1), 32'd1);
    check_eq("same_err",  32'(sb_err),     32'd0);
    alu_req(1, 'h2222);
    tick(); idle(); tick();
    #1 check_eq("same_drain", 32'(chk_busy_1), 32'd0);

    // Reset during a write cycle
    reserve_en = 1'b1; reserve_dest = 3'd2; chk_addr_1 = 3'd2;
    tick(); reserve_en = 1'b0;
    alu_req(2, 'h2020);
    tick(); idle();
    #1 check_eq("rstmid_we", 32'(bus.write_en), 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    #1;
    check_eq("rstmid_we_drop", 32'(bus.write_en), 32'd0);
    check_eq("rstmid_busy",    32'(chk_busy_1),    32'd0);
    check_eq("rstmid_err",     32'(sb_err),        32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.alu_valid = 1'($urandom_range(0, 1));
      bus.alu_dest  = REG_ADDR_W'($urandom_range(0, 7));
      bus.alu_data  = 16'($urandom);
      bus.mem_valid = ($urandom_range(0, 2) == 0);
      bus.mem_dest  = REG_ADDR_W'($urandom_range(0, 7));
      bus.mem_data  = 16'($urandom);
      reserve_en    = ($urandom_range(0, 2) == 0);
      reserve_dest  = REG_ADDR_W'($urandom_range(0, 7));
      chk_addr_1    = REG_ADDR_W'($urandom_range(0, 7));
      chk_addr_2    = REG_ADDR_W'($urandom_range(0, 7));
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_wb_ctrl.md
# gpr_wb_ctrl

Writeback controller driving the write port of the RISC-16 general purpose register file. It takes results from two producers, the ALU and the memory load unit, and arbitrates them onto the single register-file write port with a registered one-write-per-cycle output. It also keeps a per-register scoreboard of outstanding writes so the decode stage can detect read-after-write hazards on both register-file read ports.

## Interface
Parameters:
- DATA_W, 16, width of register data
- STARVE_LIMIT, 4, consecutive ALU-lost cycles before the ALU is forced to win
- CNT_W, 2, width of each per-register outstanding-write counter

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  reset, synchronous, active-high
- reserve_en  in  1  issue stage claims a destination register
- reserve_dest  in  3  register being claimed
- alu_valid / alu_ready  in / out  1 / 1  ALU result handshake
- alu_dest, alu_data  in  3, DATA_W  ALU result
- mem_valid / mem_ready  in / out  1 / 1  load result handshake
- mem_dest, mem_data  in  3, DATA_W  load result
- write_en  out  1  to register file write enable (registered)
- write_dest  out  3  to register file destination (registered)
- write_data  out  DATA_W  to register file data (registered)
- chk_addr_1, chk_addr_2  in  3  register addresses currently read by decode
- chk_busy_1, chk_busy_2  out  1  address has outstanding writes (combinational)
- sb_err  out  1  sticky scoreboard error flag

## Operation
- Transfer happens on a producer when valid && ready at posedge.
- Arbitration: mem has priority. mem_ready = 1 unless force_alu. alu_ready = !mem_valid || force_alu.
- force_alu = starve_cnt == STARVE_LIMIT. starve_cnt increments each cycle where alu_valid && !alu_ready, clears on any ALU transfer, and saturates at STARVE_LIMIT.
- Winner is latched into write_en/write_dest/write_data. With no transfer, write_en = 0 and dest/data hold their values.
- r0 is hardwired zero. A transfer with dest 0 completes the handshake, but write_en stays 0. reserve_dest 0 is ignored. chk_busy for address 0 is always 0.
- Scoreboard: one CNT_W counter per register.
  - reserve_en increments the counter for reserve_dest.
  - A committed write (write_en high at posedge) decrements the counter for write_dest.
  - If both target the same register in one cycle, the counter is unchanged.
- chk_busy_n = (counter[chk_addr_n] != 0).
- Errors, both set sb_err (cleared only by rst) with the offending counter unchanged:
  - reserve on a saturated counter (3);
  - commit to a counter at 0 with no same-cycle reserve.

## Timing
- Reset values: write_en=0, write_dest=0, write_data=0, sb_err=0, all counters 0, starve_cnt 0. alu_ready=1 and mem_ready=1 as long as no request is pending.
- Latency: a transfer at edge N gives write_en=1 during cycle N+1. The register file captures the value at edge N+1, and the counter decrements at that same edge.
- chk_busy stays 1 through cycle N+1. Decode reading in N+1 sees the old register value unless forwarding is compiled in.
- Throughput: one write per cycle, with no internal buffering and no backpressure from the register file.
- rst mid-operation drops any in-flight write (write_en=0 next cycle) and clears the scoreboard. Producers must re-present.

## Configuration
- GPR_WB_FWD_EN defined:
  - Adds outputs fwd_hit_1/fwd_hit_2 (1 bit) and fwd_data_1/fwd_data_2 (DATA_W).
  - fwd_hit_n = write_en && write_dest == chk_addr_n && chk_addr_n != 0, with fwd_data_n = write_data.
  - chk_busy_n is masked to 0 when fwd_hit_n and the counter equals 1.
- Undefined: these ports do not exist and chk_busy is unmasked.

## Structure
- Shared package gpr_pkg holds REG_ADDR_W=3, NUM_REGS=8, DATA_W default, and enum wb_src_t {WB_NONE, WB_ALU, WB_MEM}.
- One sub-module, gpr_scoreboard, contains the counters, reserve/commit/error logic and both check ports.
- Arbitration and the output register live in the top level.

## Test plan
- Reset, then alu_valid with dest 2 and data 0x1234 → write_en=1, write_dest=2, write_data=0x1234 exactly one cycle later; alu_ready=1 throughout.
- alu_valid and mem_valid together, dests 3 and 4 → mem writes first; ALU is held off until mem_valid drops. With mem_valid held high, the ALU wins on the cycle after 4 stalled cycles (STARVE_LIMIT=4).
- reserve r5, check r5 → chk_busy=1. ALU result 0xBEEF to r5 → chk_busy falls after the write_en cycle. With GPR_WB_FWD_EN, fwd_hit=1 and fwd_data=0xBEEF during the write_en cycle, with busy masked.
- ALU result to r0 with data 0xFFFF → handshake completes, write_en stays 0. reserve r0 → chk_busy for 0 stays 0.
- reserve r1 four times → fourth sets sb_err and counter stays 3. A write to r6 with its counter at 0 also sets sb_err. Reserve r1 and commit r1 in the same cycle → counter unchanged.
- Assert rst during a write_en cycle → write_en=0 next cycle, all chk_busy=0, sb_err=0.
